// File: rtl/radar_signal_conditioner_if.sv
// Signal bundle between the raw radar pins and the conditioner.
// The source side drives the raw pins and the clear; the conditioner drives the clean outputs.
interface radar_signal_conditioner_if #(
    parameter int GLITCH_WIDTH = 16
);
    logic                    arp_in;
    logic                    acp_in;
    logic                    trig_in;
    logic                    glitch_clr;
    logic                    arp;
    logic                    acp;
    logic                    trig;
    logic                    arp_pulse;
    logic                    acp_pulse;
    logic                    trig_pulse;
    logic                    us_clk;
    logic                    us_tick;
    logic [GLITCH_WIDTH-1:0] glitch_cnt;

    modport master (
        output arp_in, acp_in, trig_in, glitch_clr,
        input  arp, acp, trig, arp_pulse, acp_pulse, trig_pulse,
        input  us_clk, us_tick, glitch_cnt
    );

    modport slave (
        input  arp_in, acp_in, trig_in, glitch_clr,
        output arp, acp, trig, arp_pulse, acp_pulse, trig_pulse,
        output us_clk, us_tick, glitch_cnt
    );
endinterface

// File: rtl/radar_signal_conditioner.sv
// Radar pin conditioner: per-channel synchroniser and stable-level glitch filter,
// rising-edge strobes, saturating reject counter and a 1 us timebase.
module radar_signal_conditioner #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8,
    parameter int GLITCH_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    radar_signal_conditioner_if.slave bus
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int FCW = $clog2(FILTER_CYCLES + 1);
    localparam int DCW = $clog2(DIV);
    localparam int GW1 = GLITCH_WIDTH + 1;
    localparam logic [FCW-1:0]          FC_LAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [DCW-1:0]          DC_LAST = DCW'(DIV - 1);
    localparam logic [DCW-1:0]          DC_HALF = DCW'(DIV / 2);
    localparam logic [GLITCH_WIDTH-1:0] G_MAX   = '1;

    // Channel order everywhere: bit 0 = ARP, bit 1 = ACP, bit 2 = TRIG.
    logic [2:0]             w_raw;
    logic [2:0]             w_s;
    logic [2:0]             w_rej;
    logic [SYNC_STAGES-1:0] r_sync [3];
    logic [FCW-1:0]         r_fc   [3];
    logic [2:0]             r_lvl;
    logic [2:0]             r_pulse;

    assign w_raw = {bus.trig_in, bus.acp_in, bus.arp_in};

    always_comb begin
        w_s   = '0;
        w_rej = '0;
        for (int c = 0; c < 3; c++) begin
            w_s[c]   = r_sync[c][SYNC_STAGES-1];
            w_rej[c] = (w_s[c] == r_lvl[c]) && (r_fc[c] != '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < 3; c++) begin
                r_sync[c] <= '0;
                r_fc[c]   <= '0;
            end
            r_lvl   <= '0;
            r_pulse <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                r_sync[c]  <= {r_sync[c][SYNC_STAGES-2:0], w_raw[c]};
                r_pulse[c] <= 1'b0;
                if (w_s[c] != r_lvl[c]) begin
                    if (r_fc[c] == FC_LAST) begin
                        r_lvl[c]   <= w_s[c];
                        r_fc[c]    <= '0;
                        r_pulse[c] <= w_s[c];
                    end else begin
                        r_fc[c] <= r_fc[c] + FCW'(1);
                    end
                end else begin
                    r_fc[c] <= '0;
                end
            end
        end
    end

    // Up to three rejects per cycle; one spare bit detects overflow for saturation.
    logic [1:0]              w_rej_n;
    logic [GLITCH_WIDTH:0]   w_gsum;
    logic [GLITCH_WIDTH-1:0] r_gcnt;

    assign w_rej_n = 2'(w_rej[0]) + 2'(w_rej[1]) + 2'(w_rej[2]);
    assign w_gsum  = {1'b0, r_gcnt} + GW1'(w_rej_n);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gcnt <= '0;
        end else if (bus.glitch_clr) begin
            r_gcnt <= '0;
        end else if (w_gsum[GLITCH_WIDTH]) begin
            r_gcnt <= G_MAX;
        end else begin
            r_gcnt <= w_gsum[GLITCH_WIDTH-1:0];
        end
    end

    logic [DCW-1:0] r_dc;
    logic [DCW-1:0] w_dc_next;
    logic           r_us_clk;
    logic           r_us_tick;

    assign w_dc_next = (r_dc == DC_LAST) ? '0 : r_dc + DCW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dc      <= '0;
            r_us_tick <= 1'b0;
            r_us_clk  <= 1'b0;
        end else begin
            r_dc      <= w_dc_next;
            r_us_tick <= (r_dc == DC_LAST);
            r_us_clk  <= (w_dc_next >= DC_HALF);
        end
    end

    assign bus.arp        = r_lvl[0];
    assign bus.acp        = r_lvl[1];
    assign bus.trig       = r_lvl[2];
    assign bus.arp_pulse  = r_pulse[0];
    assign bus.acp_pulse  = r_pulse[1];
    assign bus.trig_pulse = r_pulse[2];
    assign bus.us_clk     = r_us_clk;
    assign bus.us_tick    = r_us_tick;
    assign bus.glitch_cnt = r_gcnt;
endmodule

// File: tb/tb_radar_signal_conditioner.sv
// Bench for radar_signal_conditioner: directed table, hand sequences and random
// runs compared cycle by cycle against a window-based behavioural model.
module tb_radar_signal_conditioner;
    localparam int S      = 2;
    localparam int FC     = 8;
    localparam int GW     = 16;
    localparam int DIV    = 100;
    localparam int SAT_GW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    radar_signal_conditioner_if #(.GLITCH_WIDTH(GW))     bus ();
    radar_signal_conditioner_if #(.GLITCH_WIDTH(SAT_GW)) sat_bus ();

    radar_signal_conditioner #(
        .CLK_FREQ_HZ(100_000_000), .SYNC_STAGES(S), .FILTER_CYCLES(FC), .GLITCH_WIDTH(GW)
    ) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    // Small instance: 4-bit counter to reach saturation, odd divider (DIV = 5).
    radar_signal_conditioner #(
        .CLK_FREQ_HZ(5_000_000), .SYNC_STAGES(2), .FILTER_CYCLES(3), .GLITCH_WIDTH(SAT_GW)
    ) u_sat (.i_clk(clk), .i_rst(rst), .bus(sat_bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw sample history per channel; a level is accepted when the
    // last FC filtered samples all agree on a value different from the current level.
    bit     m_hist [3][8192];
    int     m_n;
    bit [2:0] m_lvl, m_pulse;
    longint m_gcnt;
    bit     m_tick, m_usclk;

    function automatic bit m_x(input int c, input int i);
        return (i < 1) ? 1'b0 : m_hist[c][i];
    endfunction

    task automatic model_reset();
        m_n = 0; m_lvl = '0; m_pulse = '0; m_gcnt = 0; m_tick = 0; m_usclk = 0;
    endtask

    task automatic model_step(input bit [2:0] raw, input bit clr);
        int nrej;
        int k;
        bit cur, prev, same;
        nrej = 0;
        m_n++;
        for (int c = 0; c < 3; c++) m_hist[c][m_n] = raw[c];
        k = m_n - S;
        for (int c = 0; c < 3; c++) begin
            cur  = m_x(c, k);
            prev = m_x(c, k - 1);
            same = 1'b1;
            for (int j = 0; j < FC; j++) if (m_x(c, k - j) != cur) same = 1'b0;
            m_pulse[c] = 1'b0;
            if (cur == m_lvl[c] && prev != m_lvl[c]) begin
                nrej++;
            end else if (cur != m_lvl[c] && same) begin
                m_lvl[c]   = cur;
                m_pulse[c] = cur;
            end
        end
        if (clr) m_gcnt = 0;
        else if (m_gcnt + nrej > (64'd1 << GW) - 1) m_gcnt = (64'd1 << GW) - 1;
        else m_gcnt = m_gcnt + nrej;
        m_tick  = (m_n % DIV) == 0;
        m_usclk = (m_n % DIV) >= DIV / 2;
    endtask

    function automatic logic [31:0] outs_main();
        return {8'h0, bus.arp, bus.acp, bus.trig, bus.arp_pulse, bus.acp_pulse,
                bus.trig_pulse, bus.us_clk, bus.us_tick, bus.glitch_cnt};
    endfunction

    function automatic logic [15:0] outs_sat();
        return {4'h0, sat_bus.arp, sat_bus.acp, sat_bus.trig, sat_bus.arp_pulse,
                sat_bus.acp_pulse, sat_bus.trig_pulse, sat_bus.us_clk, sat_bus.us_tick,
                sat_bus.glitch_cnt};
    endfunction

    // Called at a negedge: apply inputs, step model at the posedge, compare at the negedge.
    task automatic cycle(input bit [2:0] raw, input bit clr);
        bus.arp_in = raw[0]; bus.acp_in = raw[1]; bus.trig_in = raw[2];
        bus.glitch_clr = clr;
        @(posedge clk);
        model_step(raw, clr);
        @(negedge clk);
        check("arp", bus.arp, m_lvl[0]);
        check("acp", bus.acp, m_lvl[1]);
        check("trig", bus.trig, m_lvl[2]);
        check("arp_pulse", bus.arp_pulse, m_pulse[0]);
        check("acp_pulse", bus.acp_pulse, m_pulse[1]);
        check("trig_pulse", bus.trig_pulse, m_pulse[2]);
        check("us_tick", bus.us_tick, m_tick);
        check("us_clk", bus.us_clk, m_usclk);
        check("glitch_cnt", bus.glitch_cnt, m_gcnt);
    endtask

    // Called at a negedge (or time 0); inputs keep their current values.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("reset_outputs", outs_main(), 0);
            check("reset_outputs_sat", outs_sat(), 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit [2:0] mask;
        int       width;
        bit [2:0] exp_pulse;
        int       exp_gdelta;
        int       exp_step;
    } vec_t;
    vec_t tbl [6];

    int     t_pc [3];
    longint t_prev;
    longint t_step;

    task automatic tally();
        bit [2:0] p;
        p = {bus.trig_pulse, bus.acp_pulse, bus.arp_pulse};
        for (int c = 0; c < 3; c++) t_pc[c] += int'(p[c]);
        if (longint'(bus.glitch_cnt) - t_prev > t_step) t_step = longint'(bus.glitch_cnt) - t_prev;
        t_prev = longint'(bus.glitch_cnt);
    endtask

    initial begin
        int first_idx, cnt, ticks, last_tick, bad_gap, highs, rise_n;
        bit prev_us;
        int rem [3];
        bit [2:0] val;
        bit [2:0] raw;
        longint g0;

        tbl[0] = '{3'b010, 5,  3'b000, 1, 1};
        tbl[1] = '{3'b010, 7,  3'b000, 1, 1};
        tbl[2] = '{3'b010, 8,  3'b010, 0, 0};
        tbl[3] = '{3'b111, 3,  3'b000, 3, 3};
        tbl[4] = '{3'b100, 12, 3'b100, 0, 0};
        tbl[5] = '{3'b001, 1,  3'b000, 1, 1};

        bus.arp_in = 1'b1; bus.acp_in = 1'b0; bus.trig_in = 1'b0; bus.glitch_clr = 1'b0;
        sat_bus.arp_in = 1'b0; sat_bus.acp_in = 1'b0; sat_bus.trig_in = 1'b0;
        sat_bus.glitch_clr = 1'b0;

        // ARP high through reset release: rising acceptance on edge e0 + 9.
        do_reset(3);
        first_idx = -1; cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(3'b001, 1'b0);
            if (bus.arp_pulse) begin
                cnt++;
                if (first_idx < 0) first_idx = i;
            end
        end
        check("arp_pulse_edge", first_idx, 9);
        check("arp_pulse_count", cnt, 1);
        check("arp_level_high", bus.arp, 1);
        check("arp_no_glitch", bus.glitch_cnt, 0);
        repeat (12) cycle(3'b000, 1'b0);

        // Directed pulse-width table.
        for (int t = 0; t < 6; t++) begin
            g0 = m_gcnt;
            t_pc = '{0, 0, 0}; t_prev = longint'(bus.glitch_cnt); t_step = 0;
            for (int i = 0; i < tbl[t].width; i++) begin cycle(tbl[t].mask, 1'b0); tally(); end
            for (int i = 0; i < 30; i++) begin cycle(3'b000, 1'b0); tally(); end
            check($sformatf("tbl%0d_arp_pulses", t), t_pc[0], tbl[t].exp_pulse[0]);
            check($sformatf("tbl%0d_acp_pulses", t), t_pc[1], tbl[t].exp_pulse[1]);
            check($sformatf("tbl%0d_trig_pulses", t), t_pc[2], tbl[t].exp_pulse[2]);
            check($sformatf("tbl%0d_glitch_delta", t), longint'(bus.glitch_cnt) - g0, tbl[t].exp_gdelta);
            check($sformatf("tbl%0d_glitch_step", t), t_step, tbl[t].exp_step);
        end

        // Clear, then a 3-cycle glitch on all channels: 0 -> 3 on the reject edge (cycle 5).
        cycle(3'b000, 1'b1);
        check("clr_to_zero", bus.glitch_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            cycle((i < 3) ? 3'b111 : 3'b000, 1'b0);
            if (i == 4) check("glitch3_before", bus.glitch_cnt, 0);
        end
        check("glitch3_jump", bus.glitch_cnt, 3);
        repeat (4) cycle(3'b000, 1'b0);
        // Same glitch with the clear on the reject edge: the clear wins.
        for (int i = 0; i < 6; i++) cycle((i < 3) ? 3'b111 : 3'b000, i == 5);
        check("clr_priority", bus.glitch_cnt, 0);
        repeat (4) cycle(3'b000, 1'b0);

        // Timebase over 1000 cycles from reset release.
        do_reset(2);
        ticks = 0; last_tick = 0; bad_gap = 0; highs = 0; rise_n = -1; prev_us = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            cycle(3'b000, 1'b0);
            if (bus.us_tick) begin
                ticks++;
                if (n - last_tick != 100) bad_gap++;
                last_tick = n;
            end
            if (bus.us_clk) highs++;
            if (bus.us_clk && !prev_us && rise_n < 0) rise_n = n;
            prev_us = bus.us_clk;
        end
        check("tick_count", ticks, 10);
        check("tick_spacing_errors", bad_gap, 0);
        check("us_clk_high_cycles", highs, 500);
        check("us_clk_first_rise", rise_n, 50);

        // TRIG 20 high / 20 low with reset in the middle of a high phase.
        for (int p = 0; p < 10; p++) cycle(((p % 40) < 20) ? 3'b100 : 3'b000, 1'b0);
        do_reset(3);
        first_idx = -1; cnt = 0;
        for (int p = 13; p < 60; p++) begin
            cycle(((p % 40) < 20) ? 3'b100 : 3'b000, 1'b0);
            if (bus.trig_pulse) begin
                cnt++;
                if (first_idx < 0) first_idx = p - 13;
            end
        end
        check("trig_after_reset_edge", first_idx, 36);
        check("trig_after_reset_count", cnt, 1);
        check("trig_stub_rejected", bus.glitch_cnt, 1);

        // Random run lengths on all channels, occasional clear.
        do_reset(2);
        val = '0;
        for (int c = 0; c < 3; c++) rem[c] = $urandom_range(1, 14);
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (rem[c] == 0) begin
                    val[c] = ~val[c];
                    rem[c] = $urandom_range(1, 14);
                end
                rem[c]--;
            end
            raw = val;
            cycle(raw, $urandom_range(0, 63) == 0);
        end

        // Saturation of the 4-bit counter with single-cycle ARP glitches.
        do_reset(2);
        for (int k = 1; k <= 18; k++) begin
            sat_bus.arp_in = 1'b1;
            cycle(3'b000, 1'b0);
            sat_bus.arp_in = 1'b0;
            repeat (3) cycle(3'b000, 1'b0);
            check($sformatf("sat_cnt_%0d", k), sat_bus.glitch_cnt, (k < 15) ? k : 15);
        end
        check("sat_arp_level", sat_bus.arp, 0);
        highs = 0; ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(3'b000, 1'b0);
            if (sat_bus.us_clk) highs++;
            if (sat_bus.us_tick) ticks++;
        end
        check("sat_us_clk_high", highs, 30);
        check("sat_tick_count", ticks, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/radar_signal_conditioner.md
Name: radar_signal_conditioner

Overview:
Front-end stage between the raw radar interface pins (ARP, ACP, TRIG) and the radar statistics block. Synchronises each raw input into the CLK domain and applies a stable-level glitch filter. Emits clean conditioned levels plus single-cycle rising-edge pulses. Also generates the 1 µs timebase (US_CLK square wave and US_TICK strobe) that the statistics block counts, and keeps a saturating count of rejected glitches for diagnostics.

Parameters:
CLK_FREQ_HZ, 100000000, CLK frequency; DIV = CLK_FREQ_HZ/1000000 must be an integer >= 2
SYNC_STAGES, 2, synchroniser flop depth per input, >= 2
FILTER_CYCLES, 8, consecutive cycles a new level must persist before acceptance, 1..255
GLITCH_WIDTH, 16, width of GLITCH_CNT

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
ARP_IN  in  1  raw azimuth reference pulse, asynchronous to CLK
ACP_IN  in  1  raw azimuth change pulse, asynchronous
TRIG_IN  in  1  raw transmit trigger, asynchronous
GLITCH_CLR  in  1  synchronous clear of GLITCH_CNT
ARP  out  1  conditioned ARP level
ACP  out  1  conditioned ACP level
TRIG  out  1  conditioned TRIG level
ARP_PULSE  out  1  one-cycle strobe on accepted ARP rising transition
ACP_PULSE  out  1  as above for ACP
TRIG_PULSE  out  1  as above for TRIG
US_CLK  out  1  1 MHz square wave, registered
US_TICK  out  1  one-cycle strobe, once per µs
GLITCH_CNT  out  GLITCH_WIDTH  rejected-transition count, saturating

Behaviour:
- Reset: all synchroniser flops, filter counters, conditioned levels, pulses, US_CLK, US_TICK, divider counter and GLITCH_CNT go to 0 immediately on RST assertion. Reset mid-pulse discards any partially counted transition.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel. Its last stage is s.
- Filter, per channel: state lvl (drives ARP/ACP/TRIG) and counter fc, which is ceil(log2(FILTER_CYCLES+1)) bits wide.
  - s == lvl, fc == 0: idle.
  - s != lvl: fc increments. When s != lvl and fc == FILTER_CYCLES-1: lvl <= s, fc <= 0. On the same edge, xxx_PULSE <= 1 if s == 1. Falling acceptance produces no pulse.
  - s == lvl and fc != 0: fc <= 0 and a glitch-reject event fires for that channel.
- Filter consequences:
  - A level held for >= FILTER_CYCLES consecutive s-samples is accepted.
  - A shorter level is rejected and output is unchanged.
  - FILTER_CYCLES=1 accepts on the first differing sample, so glitches never occur.
- Latency: let e0 be the first CLK edge at which the first sync flop captures the new raw level. lvl and pulse update on edge e0 + SYNC_STAGES + FILTER_CYCLES - 1. With the defaults this is e0+9.
- Pulses are high for exactly one cycle. Minimum spacing between ACP pulses is 2*FILTER_CYCLES cycles.
- Raw input high at reset release is treated as a rising transition: the level rises and a pulse fires after the latency above.
- Channels are fully independent; simultaneous events on all three are handled in the same cycle.
- GLITCH_CNT:
  - Each cycle it adds the number of channels with a reject event (0..3).
  - It saturates at 2^GLITCH_WIDTH-1 and never wraps. Example: at MAX-1 with 3 rejects it goes to MAX.
  - GLITCH_CLR sets it to 0 and takes priority over same-cycle increments.
- Timebase:
  - Divider counter dc runs 0..DIV-1 and wraps to 0.
  - US_TICK <= 1 on the edge where dc goes DIV-1 -> 0, so one high cycle per DIV cycles.
  - US_CLK <= 1 while dc, after the update, is >= DIV/2 (integer division), else 0. The rising edge occurs once per µs; duty is exactly 50% for even DIV.
  - The divider free-runs from reset release and is unaffected by the inputs.

Test Plan:
- Reset, then ARP_IN held high (defaults) -> ARP rises and ARP_PULSE high one cycle exactly on edge e0+9. GLITCH_CNT stays 0.
- ACP_IN high for 5 CLK cycles, then low (FILTER_CYCLES=8) -> ACP stays 0, no ACP_PULSE, GLITCH_CNT=1. Repeat with a 7-cycle pulse -> rejected; 8-cycle pulse -> accepted, one pulse.
- Identical 3-cycle glitch on all three inputs on the same edge -> GLITCH_CNT increments 0->3 in one cycle. Repeat with GLITCH_CLR asserted on the increment cycle -> GLITCH_CNT=0.
- GLITCH_WIDTH=4, force 16 rejects -> GLITCH_CNT reaches 15 and stays 15.
- CLK_FREQ_HZ=100e6, run 1000 cycles after reset -> exactly 10 US_TICK pulses, 100 cycles apart. US_CLK high 50 / low 50 cycles, rising where dc goes 49 -> 50.
- TRIG_IN pulsing 20 high / 20 low, RST asserted mid-high-phase for 3 cycles -> all outputs 0 during reset. After release the first TRIG_PULSE follows the next accepted rising level with full latency; no partial-count acceptance.
